// File: rtl/bcd_display_scan.sv
// bcd_display_scan: time-multiplexed 8-digit common-anode 7-segment driver for the
// timer's packed BCD HH:MM:SS bus. Only digits 0-5 are used; digits 6-7 stay dark.
// The time is snapshotted at each frame boundary so a frame never tears. Leading
// zeros can be blanked, and the digit being edited can blink.
//
// Optional feature: define DISP_BLINK_EN to build the blink counter/phase that
// flashes the edited digit. Without it the edited digit is always lit.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-low reset
//   tm_i       - packed BCD time, [3:0]=sec units .. [23:20]=hour tens
//   edit_i     - edit mode (disables leading-zero blanking, enables blink)
//   digit_i    - edited digit, 1=sec units .. 6=hour tens; 0/7 = none
//   blank_lz_i - blank leading zeros
//   an_o       - anode enables, active-low
//   seg_o      - segments {g,f,e,d,c,b,a}, active-low
//   dp_o       - decimal point, active-low
module bcd_display_scan #(
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] tm_i,
  input  logic        edit_i,
  input  logic [2:0]  digit_i,
  input  logic        blank_lz_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

  // Elaboration-time parameter sanity
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be >= 2");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink_ticks
    $error("BLINK_TICKS must be >= 1");
  end

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [23:0]        snap_q, snap_d;
  logic [7:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               tick_c;
  logic               blink_blank_c;
  logic               lz_blank_c;
  logic [7:0]         hi_zero_c;
  logic [31:0]        snap_ext_c;
  logic [3:0]         nib_c;

  // Active-low gfedcba decode; non-BCD nibbles show a dash
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick_c = (presc_q == PRESC_MAX);

  // Prescaler, scan index and frame-boundary snapshot
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    if (tick_c) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        snap_d = tm_i;
      end
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               phase_q, phase_d;

  // Blink half-period counter in scan ticks; phase 1 = visible
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (tick_c) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Edited digit goes dark during the hidden phase; digit codes 0 and 7 never match
  assign blink_blank_c = edit_i && !phase_d && (digit_i != 3'd0) && (digit_i != 3'd7)
                         && (idx_d == (digit_i - 3'd1));
`else
  logic unused_digit;
  assign unused_digit  = ^digit_i;
  assign blink_blank_c = 1'b0;
`endif

  // hi_zero_c[i]: snapshot nibbles i..5 are all zero
  always_comb begin
    hi_zero_c = '0;
    for (int i = 0; i < 6; i++) begin
      hi_zero_c[i] = ((snap_d >> (4 * i)) == 24'h0);
    end
  end

  assign lz_blank_c = blank_lz_i && !edit_i && (idx_d != 3'd0) && hi_zero_c[idx_d];
  assign snap_ext_c = {8'h00, snap_d};
  assign nib_c      = snap_ext_c[{idx_d, 2'b00} +: 4];

  // Registered outputs follow the new index on each tick; priority dark > blink > LZ > normal
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick_c) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if ((idx_d <= 3'd5) && !blink_blank_c && !lz_blank_c) begin
        an_d  = ~(8'd1 << idx_d);
        seg_d = decode(nib_c);
        dp_d  = !((idx_d == 3'd2) || (idx_d == 3'd4));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      snap_q  <= 24'h0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule
